game_monitor: RTL



---
 rtl/game_monitor.sv | 138 +++++++++++++
 1 files changed

// File: rtl/game_monitor.sv
// game_monitor: per-frame collision detection, IDLE/PLAY/DEAD game FSM, saturating BCD score and 7-seg drive.
// Optional high-score register shown on hex3..hex5 when GAME_MONITOR_HIGH_SCORE_EN is defined.
module game_monitor #(
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  parameter int GRACE_FRAMES = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        press,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic        bird_on,
  input  logic        pipe_on,
  input  logic        pipe_pass,
  output logic        playing,
  output logic        gameover,
  output logic        frame_tick,
  output logic [11:0] score_bcd,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);
  localparam int GW = $clog2(GRACE_FRAMES + 2);
  localparam logic [6:0] ZERO = 7'b1000000;
  typedef enum logic [1:0] {IDLE, PLAY, DEAD} state_t;
  state_t state, state_n;
  logic [GW-1:0] grace, grace_n;
  logic [11:0] score_n, score_inc;
  logic coll_flag, fe, hit, fc, c0, c1;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'h7F;
    endcase
  endfunction

  assign fe  = (x == 10'(WIDTH - 1)) && (y == 9'(HEIGHT - 1));
  assign hit = bird_on && (pipe_on || y == 9'd0 || y == 9'(HEIGHT - 1));
  assign fc  = coll_flag || hit;
  assign c0  = score_bcd[3:0] == 4'd9;
  assign c1  = c0 && score_bcd[7:4] == 4'd9;

  // BCD increment that saturates at 999, so hundreds never exceeds 9
  always_comb begin
    score_inc = score_bcd;
    if (score_bcd != 12'h999) begin
      score_inc[3:0]  = c0 ? 4'd0 : score_bcd[3:0] + 4'd1;
      score_inc[7:4]  = c1 ? 4'd0 : c0 ? score_bcd[7:4] + 4'd1 : score_bcd[7:4];
      score_inc[11:8] = c1 ? score_bcd[11:8] + 4'd1 : score_bcd[11:8];
    end
  end

  always_comb begin
    state_n = state;
    grace_n = grace;
    score_n = score_bcd;
    case (state)
      IDLE: if (start && press) begin
        state_n = PLAY;
        grace_n = GW'(GRACE_FRAMES);
        score_n = '0;
      end
      PLAY: begin
        if (pipe_pass) score_n = score_inc;
        if (!start) state_n = IDLE;
        else if (fe) begin
          if (grace != '0) grace_n = grace - 1'b1;
          else if (fc) state_n = DEAD;
        end
      end
      DEAD: if (!start) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      grace      <= '0;
      score_bcd  <= '0;
      coll_flag  <= 1'b0;
      frame_tick <= 1'b0;
      playing    <= 1'b0;
      gameover   <= 1'b0;
      hex0       <= ZERO;
      hex1       <= ZERO;
      hex2       <= ZERO;
    end else begin
      state      <= state_n;
      grace      <= grace_n;
      score_bcd  <= score_n;
      coll_flag  <= fe ? 1'b0 : coll_flag || (hit && state == PLAY);
      frame_tick <= fe;
      playing    <= state_n == PLAY;
      gameover   <= state_n == DEAD;
      hex0       <= seg(score_bcd[3:0]);
      hex1       <= seg(score_bcd[7:4]);
      hex2       <= seg(score_bcd[11:8]);
    end
  end

`ifdef GAME_MONITOR_HIGH_SCORE_EN
  logic [11:0] high;
  // packed BCD orders the same as its binary value, so a plain compare suffices
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      high <= '0;
      hex3 <= ZERO;
      hex4 <= ZERO;
      hex5 <= ZERO;
    end else begin
      if (state == PLAY && state_n == DEAD && score_n > high) high <= score_n;
      hex3 <= seg(high[3:0]);
      hex4 <= seg(high[7:4]);
      hex5 <= seg(high[11:8]);
    end
  end
`else
  assign hex3 = 7'h7F;
  assign hex4 = 7'h7F;
  assign hex5 = 7'h7F;
`endif
endmodule
